// File: rtl/mux_l2_tx.sv
// mux_l2_tx: transmit-side layer-2 lane multiplexer.
// Takes one frame of four 8-bit lanes and sends it on the 16-bit L1 bus as
// two back-to-back words: high word {lane4,lane3}, then low word {lane2,lane1}.
// Optional feature macro: MUX_L2_IDLE_FILL_EN. When it is defined, idle cycles
// drive the 16'hBCBC fill pattern on data_L1. When it is undefined, idle cycles
// hold the last word on data_L1.
module mux_l2_tx (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    input  logic [7:0]  data_in3,
    input  logic [7:0]  data_in4,
    input  logic        valid_in1,
    input  logic        valid_in2,
    input  logic        valid_in3,
    input  logic        valid_in4,
    output logic        ready_out,
    output logic [15:0] data_L1,
    output logic        valid_L10,
    output logic        valid_L11,
    output logic        frame_drop,
    output logic [7:0]  frame_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOW  = 1'b1;

    localparam logic [15:0] IDLE_FILL = 16'hBCBC;

    logic [0:0]  state_q, state_d;
    logic [15:0] hold_q,  hold_d;
    logic [15:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        drop_q,  drop_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic [3:0]  valid_vec_s;
    logic        all_valid_s;
    logic        any_valid_s;

    // Word driven on the bus during an IDLE cycle that accepts no frame.
    function automatic logic [15:0] idle_word(input logic [15:0] prev);
`ifdef MUX_L2_IDLE_FILL_EN
        idle_word = IDLE_FILL;
`else
        idle_word = prev;
`endif
    endfunction

    assign valid_vec_s = {valid_in4, valid_in3, valid_in2, valid_in1};
    assign all_valid_s = (valid_vec_s == 4'b1111);
    assign any_valid_s = (valid_vec_s != 4'b0000);

    // A new frame can be taken only in IDLE and only when reset is not asserted.
    assign ready_out = (state_q == ST_IDLE) && reset;

    // Next-state logic: take a full frame, reject a partial one, or send the held low word.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = 1'b0;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (all_valid_s) begin
                    data_d  = {data_in4, data_in3};
                    hold_d  = {data_in2, data_in1};
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_LOW;
                end else begin
                    data_d  = idle_word(data_q);
                    valid_d = 1'b0;
                    drop_d  = any_valid_s;
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                // The low word always follows its high word immediately.
                data_d  = hold_q;
                valid_d = 1'b1;
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                data_d  = 16'h0000;
                valid_d = 1'b0;
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; a synchronous reset discards any frame in flight.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 16'h0000;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_L1    = data_q;
    assign valid_L10  = valid_q;
    assign valid_L11  = valid_q;
    assign frame_drop = drop_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_l2_tx.sv
// Self-checking bench for mux_l2_tx. It uses directed test-plan cases and
// randomized traffic. All checks compare the DUT with a word-queue reference model.
module tb_mux_l2_tx;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [7:0]  d1, d2, d3, d4;
    logic        v1, v2, v3, v4;
    logic        ready_out;
    logic [15:0] data_L1;
    logic        valid_L10, valid_L11, frame_drop;
    logic [7:0]  frame_cnt;

    always #5 clk_2f = ~clk_2f;

    mux_l2_tx dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .data_in1  (d1),
        .data_in2  (d2),
        .data_in3  (d3),
        .data_in4  (d4),
        .valid_in1 (v1),
        .valid_in2 (v2),
        .valid_in3 (v3),
        .valid_in4 (v4),
        .ready_out (ready_out),
        .data_L1   (data_L1),
        .valid_L10 (valid_L10),
        .valid_L11 (valid_L11),
        .frame_drop(frame_drop),
        .frame_cnt (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: these are the words still owed to the bus, in order.
    logic [15:0] m_q[$];
    logic [15:0] m_data = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_drop  = 1'b0;
    int          m_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle with the current inputs: check ready, advance the model, clock, then check outputs.
    task automatic cycle();
        logic m_ready;
        logic allv, anyv;
        #1;
        m_ready = (m_q.size() == 0) && (reset == 1'b1);
        check_eq("ready_out", {31'd0, ready_out}, {31'd0, m_ready});
        allv = v1 && v2 && v3 && v4;
        anyv = v1 || v2 || v3 || v4;
        if (!reset) begin
            m_q.delete();
            m_data  = 16'h0000;
            m_valid = 1'b0;
            m_drop  = 1'b0;
            m_cnt   = 0;
        end else begin
            m_drop = 1'b0;
            if (m_ready && allv) begin
                m_q.push_back({d4, d3});
                m_q.push_back({d2, d1});
                m_cnt = (m_cnt + 1) % 256;
            end else if (m_ready && anyv) begin
                m_drop = 1'b1;
            end
            if (m_q.size() > 0) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
`ifdef MUX_L2_IDLE_FILL_EN
                m_data = 16'hBCBC;
`endif
            end
        end
        @(posedge clk_2f);
        #1;
        check_eq("data_L1",    {16'd0, data_L1},    {16'd0, m_data});
        check_eq("valid_L10",  {31'd0, valid_L10},  {31'd0, m_valid});
        check_eq("valid_L11",  {31'd0, valid_L11},  {31'd0, m_valid});
        check_eq("frame_drop", {31'd0, frame_drop}, {31'd0, m_drop});
        check_eq("frame_cnt",  {24'd0, frame_cnt},  m_cnt[31:0]);
    endtask

    task automatic drive(input logic r, input logic [31:0] bytes, input logic [3:0] v);
        reset = r;
        {d4, d3, d2, d1} = bytes;
        {v4, v3, v2, v1} = v;
        cycle();
    endtask

    logic [15:0] b2b_exp [6] = '{16'hDDCC, 16'hBBAA, 16'h0403, 16'h0201, 16'hF3F2, 16'hF1F0};
    logic [31:0] b2b_frm [3] = '{32'hDDCCBBAA, 32'h04030201, 32'hF3F2F1F0};

    initial begin
        // Reset state
        drive(1'b0, 32'h0, 4'h0);
        drive(1'b0, 32'h0, 4'h0);
        check_eq("rst_data", {16'd0, data_L1}, 32'h0);
        check_eq("rst_cnt",  {24'd0, frame_cnt}, 32'h0);

        // Single frame
        drive(1'b1, 32'h44332211, 4'hF);
        check_eq("sf_hi", {16'd0, data_L1}, 32'h4433);
        drive(1'b1, 32'h0, 4'h0);
        check_eq("sf_lo", {16'd0, data_L1}, 32'h2211);
        drive(1'b1, 32'h0, 4'h0);
        check_eq("sf_vld_end", {31'd0, valid_L10}, 32'h0);
        check_eq("sf_cnt", {24'd0, frame_cnt}, 32'h1);
`ifdef MUX_L2_IDLE_FILL_EN
        check_eq("idle_fill", {16'd0, data_L1}, 32'hBCBC);
`else
        check_eq("idle_hold", {16'd0, data_L1}, 32'h2211);
`endif

        // Back-to-back streaming (each frame held through its LOW cycle)
        drive(1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b2b_frm[i], 4'hF);
            check_eq("b2b_word", {16'd0, data_L1}, {16'd0, b2b_exp[2*i]});
            check_eq("b2b_vld", {31'd0, valid_L10}, 32'h1);
            drive(1'b1, b2b_frm[i], 4'hF);
            check_eq("b2b_word", {16'd0, data_L1}, {16'd0, b2b_exp[2*i+1]});
            check_eq("b2b_vld", {31'd0, valid_L10}, 32'h1);
        end
        drive(1'b1, 32'h0, 4'h0);
        check_eq("b2b_cnt", {24'd0, frame_cnt}, 32'h3);

        // Partial valid, then a normal frame
        drive(1'b1, 32'h12345678, 4'b1011);
        check_eq("pv_drop", {31'd0, frame_drop}, 32'h1);
        check_eq("pv_cnt",  {24'd0, frame_cnt}, 32'h3);
        drive(1'b1, 32'h12345678, 4'hF);
        check_eq("pv_drop_end", {31'd0, frame_drop}, 32'h0);
        drive(1'b1, 32'h0, 4'h0);
        drive(1'b1, 32'h0, 4'h0);

        // Reset mid-frame: the low word must never appear
        drive(1'b1, 32'h55667788, 4'hF);
        drive(1'b0, 32'h0, 4'h0);
        check_eq("rmf_data", {16'd0, data_L1}, 32'h0);
        drive(1'b1, 32'h0, 4'h0);
        check_eq("rmf_vld", {31'd0, valid_L10}, 32'h0);

        // Reset released with all valids high: the frame is taken on the first edge
        drive(1'b0, 32'hA1A2A3A4, 4'hF);
        drive(1'b1, 32'hA1A2A3A4, 4'hF);
        check_eq("rel_hi", {16'd0, data_L1}, 32'hA1A2);

        // Counter wrap over 257 frames
        drive(1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 257; i++) begin
            logic [31:0] fr;
            fr = $urandom;
            drive(1'b1, fr, 4'hF);
            if (i == 254) check_eq("wrap_255", {24'd0, frame_cnt}, 32'd255);
            if (i == 255) check_eq("wrap_0",   {24'd0, frame_cnt}, 32'd0);
            if (i == 256) check_eq("wrap_1",   {24'd0, frame_cnt}, 32'd1);
            drive(1'b1, fr, 4'hF);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [3:0] v;
            r = ($urandom_range(0, 29) != 0);
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            drive(r, $urandom, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
